// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART for the I/O bank: TX/RX FIFOs, sticky status flags, programmable baud divider.
// Define UART_LOOPBACK_EN to make BAUDDIV[16] (LOOP) writable and route txd back into the receiver.
module mmio_uart #(
  parameter int          TX_DEPTH    = 8,
  parameter int          RX_DEPTH    = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  memWrite,
  input  logic [10:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        txd,
  input  logic        rxd
);

  localparam int TXW = $clog2(TX_DEPTH);
  localparam int RXW = $clog2(RX_DEPTH);
  localparam logic [TXW:0] TX_FULL = TX_DEPTH[TXW:0];
  localparam logic [RXW:0] RX_FULL = RX_DEPTH[RXW:0];

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uartState_e;

  logic [7:0]     txMem_r [TX_DEPTH];
  logic [TXW-1:0] txWr_r, txRd_r;
  logic [TXW:0]   txCount_r;
  logic [7:0]     rxMem_r [RX_DEPTH];
  logic [RXW-1:0] rxWr_r, rxRd_r;
  logic [RXW:0]   rxCount_r;
  logic [15:0]    baud_r, effDiv_s;
  logic           rxOvr_r, frErr_r, txOvf_r;
  uartState_e     txState_r, rxState_r;
  logic [15:0]    txDiv_r, txCnt_r, rxDiv_r, rxCnt_r;
  logic [2:0]     txBit_r, rxBit_r;
  logic [7:0]     txByte_r, rxShift_r;
  logic           txd_r, sync1_r, sync2_r, prev_r, rxIn_s, loopBit_s;
  logic           txPushReq_s, txPush_s, txPop_s, txOvfSet_s, txFull_s, txNotEmpty_s;
  logic           rxPop_s, rxPush_s, rxOvrSet_s, frErrSet_s, rxStop_s, rxFull_s, rxNotEmpty_s;
  logic           statWr_s, baudSel_s, unusedBits_s;
  logic [4:0]     txCount5_s, rxCount5_s;
  logic [31:0]    status_s;

  assign effDiv_s     = (baud_r < 16'd2) ? 16'd2 : baud_r;
  assign baudSel_s    = en && (addr[1:0] == 2'd3);
  assign statWr_s     = en && memWrite[0] && (addr[1:0] == 2'd2);

  assign txFull_s     = (txCount_r == TX_FULL);
  assign txNotEmpty_s = (txCount_r != '0);
  assign txPushReq_s  = en && memWrite[0] && (addr[1:0] == 2'd0);
  assign txPop_s      = txNotEmpty_s &&
                        ((txState_r == IDLE) || ((txState_r == STOP) && (txCnt_r == 16'd0)));
  // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
  assign txPush_s     = txPushReq_s && (!txFull_s || txPop_s);
  assign txOvfSet_s   = txPushReq_s && !txPush_s;

  assign rxFull_s     = (rxCount_r == RX_FULL);
  assign rxNotEmpty_s = (rxCount_r != '0);
  assign rxPop_s      = en && (memWrite == 4'b0000) && (addr[1:0] == 2'd1) && rxNotEmpty_s;
  assign rxStop_s     = (rxState_r == STOP) && (rxCnt_r == 16'd0);
  assign rxPush_s     = rxStop_s && sync2_r && (!rxFull_s || rxPop_s);
  assign rxOvrSet_s   = rxStop_s && sync2_r && rxFull_s && !rxPop_s;
  assign frErrSet_s   = rxStop_s && !sync2_r;

  assign txCount5_s   = 5'(txCount_r);
  assign rxCount5_s   = 5'(rxCount_r);
  assign status_s     = {16'b0, rxCount5_s[3:0], txCount5_s[3:0], 1'b0, txOvf_r, frErr_r, rxOvr_r,
                         rxFull_s, !rxNotEmpty_s, !txNotEmpty_s && (txState_r == IDLE), txFull_s};
  assign txd          = txd_r;

`ifdef UART_LOOPBACK_EN
  logic loop_r;
  assign loopBit_s    = loop_r;
  assign rxIn_s       = loop_r ? txd_r : rxd;
  assign unusedBits_s = ^{addr[10:2], wdata[31:17], memWrite[3], txCount5_s[4], rxCount5_s[4]};

  // LOOP bit of BAUDDIV
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loop_r <= 1'b0;
    end else if (baudSel_s && memWrite[2]) begin
      loop_r <= wdata[16];
    end
  end
`else
  assign loopBit_s    = 1'b0;
  assign rxIn_s       = rxd;
  assign unusedBits_s = ^{addr[10:2], wdata[31:16], memWrite[3:2], txCount5_s[4], rxCount5_s[4]};
`endif

  // FIFO storage (no reset needed; occupancy is tracked by the counters)
  always_ff @(posedge clk) begin
    if (txPush_s) txMem_r[txWr_r] <= wdata[7:0];
    if (rxPush_s) rxMem_r[rxWr_r] <= rxShift_r;
  end

  // FIFO pointers and counts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txWr_r <= '0; txRd_r <= '0; txCount_r <= '0;
      rxWr_r <= '0; rxRd_r <= '0; rxCount_r <= '0;
    end else begin
      if (txPush_s) txWr_r <= txWr_r + 1'b1;
      if (txPop_s)  txRd_r <= txRd_r + 1'b1;
      if (rxPush_s) rxWr_r <= rxWr_r + 1'b1;
      if (rxPop_s)  rxRd_r <= rxRd_r + 1'b1;
      txCount_r <= txCount_r + (TXW+1)'(txPush_s) - (TXW+1)'(txPop_s);
      rxCount_r <= rxCount_r + (RXW+1)'(rxPush_s) - (RXW+1)'(rxPop_s);
    end
  end

  // Sticky flags (set wins over a same-cycle W1C) and baud divider
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxOvr_r <= 1'b0; frErr_r <= 1'b0; txOvf_r <= 1'b0;
      baud_r  <= DEFAULT_DIV;
    end else begin
      rxOvr_r <= (rxOvr_r && !(statWr_s && wdata[4])) || rxOvrSet_s;
      frErr_r <= (frErr_r && !(statWr_s && wdata[5])) || frErrSet_s;
      txOvf_r <= (txOvf_r && !(statWr_s && wdata[6])) || txOvfSet_s;
      if (baudSel_s && memWrite[0]) baud_r[7:0]  <= wdata[7:0];
      if (baudSel_s && memWrite[1]) baud_r[15:8] <= wdata[15:8];
    end
  end

  // Transmitter; each state lasts txDiv_r clocks, divider frozen per frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txState_r <= IDLE; txd_r <= 1'b1; txDiv_r <= 16'd2; txCnt_r <= 16'd0;
      txBit_r <= 3'd0; txByte_r <= 8'd0;
    end else begin
      case (txState_r)
        IDLE, STOP: begin
          if (txState_r == STOP && txCnt_r != 16'd0) begin
            txCnt_r <= txCnt_r - 16'd1;
          end else if (txPop_s) begin
            txByte_r <= txMem_r[txRd_r]; txDiv_r <= effDiv_s; txCnt_r <= effDiv_s - 16'd1;
            txd_r <= 1'b0; txState_r <= START;
          end else begin
            txd_r <= 1'b1; txState_r <= IDLE;
          end
        end
        START: begin
          if (txCnt_r != 16'd0) begin
            txCnt_r <= txCnt_r - 16'd1;
          end else begin
            txCnt_r <= txDiv_r - 16'd1; txd_r <= txByte_r[0]; txBit_r <= 3'd0; txState_r <= DATA;
          end
        end
        DATA: begin
          if (txCnt_r != 16'd0) begin
            txCnt_r <= txCnt_r - 16'd1;
          end else begin
            txCnt_r <= txDiv_r - 16'd1;
            if (txBit_r == 3'd7) begin
              txd_r <= 1'b1; txState_r <= STOP;
            end else begin
              txBit_r <= txBit_r + 3'd1; txd_r <= txByte_r[txBit_r + 3'd1];
            end
          end
        end
        default: begin
          txState_r <= IDLE; txd_r <= 1'b1;
        end
      endcase
    end
  end

  // rxd synchronizer plus one extra stage for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b1; sync2_r <= 1'b1; prev_r <= 1'b1;
    end else begin
      sync1_r <= rxIn_s; sync2_r <= sync1_r; prev_r <= sync2_r;
    end
  end

  // Receiver; half-bit wait after the start edge, then full-bit sampling
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxState_r <= IDLE; rxDiv_r <= 16'd2; rxCnt_r <= 16'd0; rxBit_r <= 3'd0; rxShift_r <= 8'd0;
    end else begin
      case (rxState_r)
        IDLE: begin
          if (prev_r && !sync2_r) begin
            rxDiv_r <= effDiv_s; rxCnt_r <= {1'b0, effDiv_s[15:1]} - 16'd1; rxState_r <= START;
          end
        end
        START: begin
          if (rxCnt_r != 16'd0) begin
            rxCnt_r <= rxCnt_r - 16'd1;
          end else if (sync2_r) begin
            rxState_r <= IDLE;
          end else begin
            rxCnt_r <= rxDiv_r - 16'd1; rxBit_r <= 3'd0; rxState_r <= DATA;
          end
        end
        DATA: begin
          if (rxCnt_r != 16'd0) begin
            rxCnt_r <= rxCnt_r - 16'd1;
          end else begin
            rxShift_r[rxBit_r] <= sync2_r; rxCnt_r <= rxDiv_r - 16'd1;
            if (rxBit_r == 3'd7) rxState_r <= STOP;
            else                 rxBit_r <= rxBit_r + 3'd1;
          end
        end
        STOP: begin
          if (rxCnt_r != 16'd0) rxCnt_r <= rxCnt_r - 16'd1;
          else                  rxState_r <= IDLE;
        end
        default: rxState_r <= IDLE;
      endcase
    end
  end

  // Read-data mux
  always_comb begin
    rdata = 32'b0;
    if (en) begin
      case (addr[1:0])
        2'd1:    rdata = rxNotEmpty_s ? {23'b0, 1'b1, rxMem_r[rxRd_r]} : 32'b0;
        2'd2:    rdata = status_s;
        2'd3:    rdata = {15'b0, loopBit_s, baud_r};
        default: rdata = 32'b0;
      endcase
    end else begin
      rdata = 32'b0;
    end
  end

endmodule

// File: tb/tb_mmio_uart.sv
// Directed/randomized bench for mmio_uart: bus tasks, a serial frame checker and queue-based models.
module tb_mmio_uart;

  logic        clk, rst, en, txd, rxd;
  logic [3:0]  memWrite;
  logic [10:0] addr;
  logic [31:0] wdata, rdata, d;
  int          compares = 0, errors = 0, div;
  logic [7:0]  bytes [10];
  logic [7:0]  q [$];
  logic [7:0]  b;
  bit          ovr;

  mmio_uart dut (.clk(clk), .rst(rst), .en(en), .memWrite(memWrite), .addr(addr),
                 .wdata(wdata), .rdata(rdata), .txd(txd), .rxd(rxd));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expStatus(input int txc, input int rxc, input bit txIdle,
                                            input bit rxOvr, input bit frErr, input bit txOvf);
    logic [31:0] s;
    s = 32'b0;
    s[0] = (txc == 8);
    s[1] = (txc == 0) && txIdle;
    s[2] = (rxc == 0);
    s[3] = (rxc == 8);
    s[4] = rxOvr;
    s[5] = frErr;
    s[6] = txOvf;
    s[11:8]  = 4'(txc);
    s[15:12] = 4'(rxc);
    return s;
  endfunction

  task automatic busWrite(input logic [1:0] a, input logic [31:0] v, input logic [3:0] be);
    @(negedge clk);
    en = 1'b1; memWrite = be; addr = {9'b0, a}; wdata = v;
    @(posedge clk); #1;
    en = 1'b0; memWrite = 4'b0000;
  endtask

  task automatic busRead(input logic [1:0] a, output logic [31:0] v);
    @(negedge clk);
    en = 1'b1; memWrite = 4'b0000; addr = {9'b0, a};
    #2 v = rdata;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  // Called at 1 ns after the edge where the frame starts; samples each bit mid-cell.
  task automatic checkFrame(input logic [7:0] v, input int dv, input string tag);
    logic [9:0] bits;
    bits = {1'b1, v, 1'b0};
    for (int k = 0; k < 10; k++) begin
      repeat (dv / 2) @(posedge clk);
      #1 check(tag, {31'b0, txd}, {31'b0, bits[k]});
      repeat (dv - dv / 2) @(posedge clk);
      #1;
    end
  endtask

  task automatic sendFrame(input logic [7:0] v, input logic stopBit, input int dv);
    @(negedge clk); rxd = 1'b0;
    repeat (dv) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = v[i];
      repeat (dv) @(negedge clk);
    end
    rxd = stopBit;
    repeat (dv) @(negedge clk);
    rxd = 1'b1;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0; en = 1'b0; memWrite = 4'b0; addr = 11'b0; wdata = 32'b0; rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("reset_txd", {31'b0, txd}, 32'd1);
    check("reset_rdata_en_low", rdata, 32'd0);
    @(negedge clk) rst = 1'b1;
    busRead(2'd2, d); check("reset_status", d, expStatus(0, 0, 1, 0, 0, 0));
    busRead(2'd3, d); check("reset_bauddiv", d, 32'd434);

    // Single TX frame at divider 4
    busWrite(2'd3, 32'd4, 4'b0011);
    busRead(2'd3, d); check("bauddiv_4", d, 32'd4);
    busWrite(2'd0, 32'hA5, 4'b0001);
    check("tx_idle_at_write", {31'b0, txd}, 32'd1);
    @(posedge clk); #1;
    check("tx_start_edge", {31'b0, txd}, 32'd0);
    checkFrame(8'hA5, 4, "tx_A5");
    busRead(2'd2, d); check("tx_empty_after_frame", d, expStatus(0, 0, 1, 0, 0, 0));

    // Three random back-to-back frames at a random divider
    div = $urandom_range(2, 5);
    for (int i = 0; i < 3; i++) bytes[i] = 8'($urandom);
    busWrite(2'd3, 32'(div), 4'b0011);
    busWrite(2'd0, {24'b0, bytes[0]}, 4'b0001);
    fork
      begin
        busWrite(2'd0, {24'b0, bytes[1]}, 4'b0001);
        busWrite(2'd0, {24'b0, bytes[2]}, 4'b0001);
      end
      begin
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) checkFrame(bytes[i], div, "tx_rand");
      end
    join
    busRead(2'd2, d); check("tx_rand_done", d, expStatus(0, 0, 1, 0, 0, 0));

    // BAUDDIV=0 reads back 0 but transmits at divider 2
    busWrite(2'd3, 32'd0, 4'b0011);
    busRead(2'd3, d); check("bauddiv_0", d, 32'd0);
    b = 8'($urandom);
    busWrite(2'd0, {24'b0, b}, 4'b0001);
    @(posedge clk); #1;
    checkFrame(b, 2, "tx_min_div");

    // RX single frame
    busWrite(2'd3, 32'd4, 4'b0011);
    sendFrame(8'h3C, 1'b1, 4);
    repeat (3) @(posedge clk);
    busRead(2'd1, d); check("rx_3C", d, 32'h13C);
    busRead(2'd1, d); check("rx_empty_read", d, 32'd0);
    busRead(2'd2, d); check("rx_status_empty", d, expStatus(0, 0, 1, 0, 0, 0));

    // Nine random frames without reads: FIFO fills, last one overflows
    ovr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      sendFrame(b, 1'b1, 4);
      if (q.size() < 8) q.push_back(b);
      else ovr = 1'b1;
    end
    repeat (3) @(posedge clk);
    busRead(2'd2, d); check("rx_overflow_status", d, expStatus(0, q.size(), 1, ovr, 0, 0));
    while (q.size() > 0) begin
      b = q.pop_front();
      busRead(2'd1, d); check("rx_drain", d, {23'b0, 1'b1, b});
    end
    busWrite(2'd2, 32'h10, 4'b0001);
    busRead(2'd2, d); check("rxovr_clear", d, expStatus(0, 0, 1, 0, 0, 0));

    // Framing error, then a one-clock glitch
    sendFrame(8'($urandom), 1'b0, 4);
    repeat (4) @(posedge clk);
    busRead(2'd2, d); check("frerr_set", d, expStatus(0, 0, 1, 0, 1, 0));
    busWrite(2'd2, 32'h20, 4'b0001);
    @(negedge clk) rxd = 1'b0;
    @(negedge clk) rxd = 1'b1;
    repeat (48) @(posedge clk);
    busRead(2'd2, d); check("glitch_ignored", d, expStatus(0, 0, 1, 0, 0, 0));

    // TX overflow: 10 writes at divider 2, 9 accepted
    busWrite(2'd3, 32'd2, 4'b0011);
    for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom);
    busWrite(2'd0, {24'b0, bytes[0]}, 4'b0001);
    fork
      begin
        for (int i = 1; i < 10; i++) busWrite(2'd0, {24'b0, bytes[i]}, 4'b0001);
        busRead(2'd2, d); check("txovf_status", d, expStatus(8, 0, 0, 0, 0, 1));
      end
      begin
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) checkFrame(bytes[i], 2, "tx_fifo_drain");
      end
    join
    busWrite(2'd2, 32'h40, 4'b0001);
    busRead(2'd2, d); check("txovf_clear", d, expStatus(0, 0, 1, 0, 0, 0));

    // Reset in the middle of a frame
    busWrite(2'd3, 32'd16, 4'b0011);
    busWrite(2'd0, 32'h00, 4'b0001);
    repeat (20) @(posedge clk);
    #2 check("midframe_txd_low", {31'b0, txd}, 32'd0);
    rst = 1'b0;
    #1 check("midframe_reset_txd", {31'b0, txd}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    busRead(2'd2, d); check("midframe_reset_status", d, expStatus(0, 0, 1, 0, 0, 0));
    busRead(2'd3, d); check("midframe_reset_baud", d, 32'd434);

`ifdef UART_LOOPBACK_EN
    busWrite(2'd3, 32'h0001_0002, 4'b0111);
    busRead(2'd3, d); check("loop_baud", d, 32'h0001_0002);
    busWrite(2'd0, 32'h55, 4'b0001);
    busWrite(2'd0, 32'hAA, 4'b0001);
    repeat (60) @(posedge clk);
    busRead(2'd1, d); check("loop_55", d, 32'h155);
    busRead(2'd1, d); check("loop_AA", d, 32'h1AA);
`else
    busWrite(2'd3, 32'h0001_0002, 4'b0111);
    busRead(2'd3, d); check("loop_ignored", d, 32'h0000_0002);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
